data_mem_ctrl: RTL

Parametrised data memory for the single-cycle MIPS datapath's successor. It supports byte, halfword and word loads and stores, little-endian byte lanes, and sign- or zero-extended loads. Accesses use a request/ready/done handshake with configurable wait states, and misaligned accesses are flagged. After reset the array is zeroed by a hardware init sweep. The block sits between the ALU result / rt operand and the write-back mux.

---
 rtl/data_mem_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores with little-endian lanes,
// sign/zero-extended loads, req/ready/done handshake with WAIT_CYCLES wait states,
// misalignment flagging and a post-reset zeroing sweep of the array.
// Optional feature: define DM_TRACE_EN to print a trace line per completed access
// and a one-time "DM init done" message.
module data_mem_ctrl #(
  parameter int unsigned  DEPTH       = 32,
  parameter int unsigned  WAIT_CYCLES = 1,
  localparam int unsigned ADDR_W      = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned IdxW     = ADDR_W - 2;
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StInit, StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cap_we_q, cap_we_d;
  logic [1:0]        cap_size_q, cap_size_d;
  logic              cap_uns_q, cap_uns_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]       cap_wdata_q, cap_wdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [IdxW-1:0]   mem_widx;
  logic [31:0]       mem_wword;

  // Operation being completed: live inputs when WAIT_CYCLES=0 finishes on the accepting edge.
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [31:0]       st_word;
  logic              mis;
  logic              enter_resp;

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign err   = err_q;

  // Select the operand source and decode the access against the addressed word.
  always_comb begin
    op_we    = (state_q == StIdle) ? we    : cap_we_q;
    op_size  = (state_q == StIdle) ? size  : cap_size_q;
    op_uns   = (state_q == StIdle) ? uns   : cap_uns_q;
    op_addr  = (state_q == StIdle) ? addr  : cap_addr_q;
    op_wdata = (state_q == StIdle) ? wdata : cap_wdata_q;

    rd_word = mem_q[op_addr[ADDR_W-1:2]];
    ld_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
    ld_half = rd_word[{op_addr[1], 4'b0000} +: 16];

    case (op_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = op_addr[0];
      2'b10:   mis = |op_addr[1:0];
      default: mis = 1'b1;
    endcase

    case (op_size)
      2'b00:   ld_val = {{24{~op_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{~op_uns & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase

    st_word = rd_word;
    case (op_size)
      2'b00:   st_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      2'b01:   st_word[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      default: st_word = op_wdata;
    endcase
  end

  // Next-state logic for the controller FSM, its registered outputs and the array write port.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cap_we_d    = cap_we_q;
    cap_size_d  = cap_size_q;
    cap_uns_d   = cap_uns_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_widx    = op_addr[ADDR_W-1:2];
    mem_wword   = st_word;
    enter_resp  = 1'b0;

    case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_widx  = idx_q;
        mem_wword = 32'h0;
        if (idx_q == IdxW'(DEPTH - 1)) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StIdle: begin
        if (req) begin
          cap_we_d    = we;
          cap_size_d  = size;
          cap_uns_d   = uns;
          cap_addr_d  = addr;
          cap_wdata_d = wdata;
          ready_d     = 1'b0;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: state_d = StInit;
    endcase

    // Completion: commit the store (if legal) and load the response registers.
    if (enter_resp) begin
      state_d   = StResp;
      done_d    = 1'b1;
      err_d     = mis;
      rdata_d   = (mis || op_we) ? 32'h0 : ld_val;
      mem_we    = op_we & ~mis;
      mem_widx  = op_addr[ADDR_W-1:2];
      mem_wword = st_word;
    end
  end

  // Controller state and registered outputs; rst dominates any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      idx_q       <= '0;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_size_q  <= 2'b00;
      cap_uns_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= 32'h0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_size_q  <= cap_size_d;
      cap_uns_q   <= cap_uns_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Storage array; no reset here because the init sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_widx] <= mem_wword;
    end
  end

`ifdef DM_TRACE_EN
  // Simulation trace of completed accesses and of the end of the init sweep.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp) begin
      $display("DM %s size=%0d addr=0x%0h wdata=0x%08h rdata=0x%08h err=%0b",
               op_we ? "store" : "load", op_size, op_addr, op_wdata, rdata_d, mis);
    end
    if (!rst && state_q == StInit && state_d == StIdle) begin
      $display("DM init done");
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule
